hd44780_bus_reader: RTL and testbench

Read-side engine for the HD44780 LCD bus. It issues a single read cycle (RS/RW/E sequencing) and returns either the busy-flag/address-counter byte or a data-RAM byte. It can optionally repeat busy-flag reads until BF clears or a poll limit is reached. It sits beside the write path and shares the LCD pins through the top-level mux, which tristates the data bus while `lcd_rw` is high.

---
 rtl/hd44780_bus_reader.sv | 200 ++++++++++++++++++++
 tb/tb_hd44780_bus_reader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hd44780_bus_reader.sv
// hd44780_bus_reader
//   Read-side engine for the HD44780 LCD bus. One request performs a read
//   cycle with RS/RW/E sequencing and returns either the busy-flag/address
//   counter byte (rs_in=0) or a data-RAM byte (rs_in=1). A busy-flag read can
//   optionally be repeated until BF clears or MAX_POLLS reads have been made.
//
// Parameters
//   FOUR_BIT      : 1 = two nibble strobes per byte on lcd_db_in[7:4], high first
//   SETUP_CYCLES  : RS/RW setup before the first E rise (>=1)
//   E_HIGH_CYCLES : E high time per strobe (>=1)
//   E_LOW_CYCLES  : E low time after each strobe (>=1)
//   MAX_POLLS     : max reads per polled request, first read included (>=1)
//
// Ports
//   clk, rst      : clock, asynchronous active-low reset
//   start         : request, accepted only while busy=0
//   rs_in, poll   : register select / poll enable, latched on accept
//   busy          : high in every state except IDLE
//   done          : one-cycle completion pulse
//   timeout       : with done, poll ran out of reads while BF was still 1
//   data          : last completed byte, held until the next done
//   lcd_rs/rw/e   : LCD control pins (rw=1 tells the pin mux to tristate DB)
//   lcd_db_in     : LCD data bus input
module hd44780_bus_reader #(
  parameter int FOUR_BIT      = 0,
  parameter int SETUP_CYCLES  = 2,
  parameter int E_HIGH_CYCLES = 6,
  parameter int E_LOW_CYCLES  = 6,
  parameter int MAX_POLLS     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs_in,
  input  logic       poll,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [7:0] data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  input  logic [7:0] lcd_db_in
);

  // One down-counter times every phase, so it is sized for the longest one.
  localparam int MAX_CYC =
    (SETUP_CYCLES > E_HIGH_CYCLES)
      ? ((SETUP_CYCLES  > E_LOW_CYCLES) ? SETUP_CYCLES  : E_LOW_CYCLES)
      : ((E_HIGH_CYCLES > E_LOW_CYCLES) ? E_HIGH_CYCLES : E_LOW_CYCLES);
  localparam int CNT_W  = $clog2(MAX_CYC) + 1;
  localparam int PCNT_W = $clog2(MAX_POLLS) + 1;

  localparam logic [CNT_W-1:0]  SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  EHI_LD   = CNT_W'(E_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  ELO_LD   = CNT_W'(E_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PCNT_W-1:0] PCNT_ONE = PCNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_EHI,
    S_ELO,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [PCNT_W-1:0] pcnt_q;     // completed reads minus one in this request
  logic              nib_q;      // 1 = high nibble captured, low nibble pending
  logic              rs_q;
  logic              poll_q;
  logic [7:0]        rd_byte_q;  // byte being assembled from the bus
  logic              busy_q;
  logic              done_q;
  logic              timeout_q;
  logic [7:0]        data_q;
  logic              lcd_rs_q;
  logic              lcd_rw_q;
  logic              lcd_e_q;

  // BF still set on a polled status read: another read is wanted, and it is
  // allowed only while the read budget is not exhausted.
  logic bf_pending;
  logic poll_again;
  assign bf_pending = poll_q && !rs_q && rd_byte_q[7];
  assign poll_again = bf_pending && ((int'(pcnt_q) + 1) < MAX_POLLS);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, whatever the statement order below.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pcnt_q    <= '0;
      nib_q     <= 1'b0;
      rs_q      <= 1'b0;
      poll_q    <= 1'b0;
      rd_byte_q <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      data_q    <= 8'h00;
      lcd_rs_q  <= 1'b0;
      lcd_rw_q  <= 1'b0;
      lcd_e_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rs_q     <= rs_in;
            poll_q   <= poll;
            lcd_rs_q <= rs_in;
            lcd_rw_q <= 1'b1;
            busy_q   <= 1'b1;
            pcnt_q   <= '0;
            nib_q    <= 1'b0;
            cnt_q    <= SETUP_LD;
            state_q  <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (cnt_q == '0) begin
            lcd_e_q <= 1'b1;
            cnt_q   <= EHI_LD;
            state_q <= S_EHI;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        S_EHI: begin
          if (cnt_q == '0) begin
            // The bus is captured on the same edge that drops E.
            if (FOUR_BIT != 0) begin
              if (!nib_q) rd_byte_q[7:4] <= lcd_db_in[7:4];
              else        rd_byte_q[3:0] <= lcd_db_in[7:4];
              nib_q <= ~nib_q;
            end else begin
              rd_byte_q <= lcd_db_in;
            end
            lcd_e_q <= 1'b0;
            cnt_q   <= ELO_LD;
            state_q <= S_ELO;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        S_ELO: begin
          if (cnt_q == '0) begin
            if ((FOUR_BIT != 0) && nib_q) begin
              // Low nibble strobe: RS/RW already stable, no setup phase.
              lcd_e_q <= 1'b1;
              cnt_q   <= EHI_LD;
              state_q <= S_EHI;
            end else if (poll_again) begin
              pcnt_q  <= pcnt_q + PCNT_ONE;
              nib_q   <= 1'b0;
              lcd_e_q <= 1'b1;
              cnt_q   <= EHI_LD;
              state_q <= S_EHI;
            end else begin
              done_q    <= 1'b1;
              data_q    <= rd_byte_q;
              timeout_q <= bf_pending;
              lcd_rw_q  <= 1'b0;
              lcd_rs_q  <= 1'b0;
              state_q   <= S_DONE;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        S_DONE: begin
          // start is deliberately not looked at here; busy drops for at
          // least one cycle before the next request can be taken.
          done_q    <= 1'b0;
          timeout_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign timeout = timeout_q;
  assign data    = data_q;
  assign lcd_rs  = lcd_rs_q;
  assign lcd_rw  = lcd_rw_q;
  assign lcd_e   = lcd_e_q;

endmodule

// File: tb/tb_hd44780_bus_reader.sv
// tb_hd44780_bus_reader
//   Three instances share one clock and reset: u0 defaults (8-bit), u1 with
//   FOUR_BIT=1, u2 with MAX_POLLS=3. Stimulus pushes the expected response of
//   each request into a per-instance queue; a negedge monitor pops and
//   compares on every done and also checks latency from accept, E pulse
//   count, RS/RW stability and the idle gap between back-to-back requests.
//   A bus model per instance drives lcd_db_in from a table indexed by the
//   number of E strobes completed in the current request.
module tb_hd44780_bus_reader;

  typedef struct {
    logic [7:0] data;
    logic       to;
    int         lat;     // edges from accept to the done cycle
    int         pulses;  // E strobes in the request
    logic       rs;
    int         gap;     // idle cycles before this accept, -1 = don't care
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start   [3];
  logic       rs_in   [3];
  logic       poll    [3];
  logic [7:0] db      [3];
  logic       busy    [3];
  logic       done    [3];
  logic       timeout [3];
  logic [7:0] data    [3];
  logic       lcd_rs  [3];
  logic       lcd_rw  [3];
  logic       lcd_e   [3];

  always #5 clk = ~clk;

  hd44780_bus_reader u0 (
    .clk(clk), .rst(rst), .start(start[0]), .rs_in(rs_in[0]), .poll(poll[0]),
    .busy(busy[0]), .done(done[0]), .timeout(timeout[0]), .data(data[0]),
    .lcd_rs(lcd_rs[0]), .lcd_rw(lcd_rw[0]), .lcd_e(lcd_e[0]), .lcd_db_in(db[0])
  );

  hd44780_bus_reader #(.FOUR_BIT(1)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .rs_in(rs_in[1]), .poll(poll[1]),
    .busy(busy[1]), .done(done[1]), .timeout(timeout[1]), .data(data[1]),
    .lcd_rs(lcd_rs[1]), .lcd_rw(lcd_rw[1]), .lcd_e(lcd_e[1]), .lcd_db_in(db[1])
  );

  hd44780_bus_reader #(.MAX_POLLS(3)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .rs_in(rs_in[2]), .poll(poll[2]),
    .busy(busy[2]), .done(done[2]), .timeout(timeout[2]), .data(data[2]),
    .lcd_rs(lcd_rs[2]), .lcd_rw(lcd_rw[2]), .lcd_e(lcd_e[2]), .lcd_db_in(db[2])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard queues, one per instance.
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  function automatic int qsz(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qpeek(input int i);
    case (i)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic exp_t qpop(input int i);
    exp_t e;
    case (i)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    return e;
  endfunction

  task automatic qpush(input int i, input exp_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic to, input int lat,
                              input int pulses, input logic rs, input int gap);
    exp_t e;
    e.data = d; e.to = to; e.lat = lat; e.pulses = pulses; e.rs = rs; e.gap = gap;
    return e;
  endfunction

  // Bus model tables and monitor state.
  logic [7:0] tab      [3][8];
  logic       busy_p   [3];
  logic       e_p      [3];
  int         acc_cyc  [3];
  int         fall_cyc [3];
  int         pulses   [3];
  int         falls    [3];
  logic       bad_rsrw [3];
  logic       cur_rs   [3];
  bit         expect_abort = 1'b0;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (busy[i] === 1'b1 && busy_p[i] !== 1'b1) begin
        acc_cyc[i]  = cyc;
        pulses[i]   = 0;
        falls[i]    = 0;
        bad_rsrw[i] = 1'b0;
        if (qsz(i) != 0) begin
          exp_t e;
          e = qpeek(i);
          cur_rs[i] = e.rs;
          if (e.gap >= 0)
            check($sformatf("dut%0d_idle_gap", i), cyc - fall_cyc[i], e.gap);
        end else if (!expect_abort) begin
          checks++;
          errors++;
          $display("FAIL dut%0d_unexpected_accept: got accept expected none (cycle %0d)", i, cyc);
        end
      end
      if (busy[i] !== 1'b1 && busy_p[i] === 1'b1) fall_cyc[i] = cyc;
      if (lcd_e[i] === 1'b1 && e_p[i] !== 1'b1) pulses[i]++;
      if (lcd_e[i] !== 1'b1 && e_p[i] === 1'b1) falls[i]++;
      if (busy[i] === 1'b1 && done[i] !== 1'b1 &&
          (lcd_rw[i] !== 1'b1 || lcd_rs[i] !== cur_rs[i]))
        bad_rsrw[i] = 1'b1;
      if (done[i] === 1'b1) begin
        if (qsz(i) == 0) begin
          checks++;
          errors++;
          $display("FAIL dut%0d_unexpected_done: got done expected none (cycle %0d)", i, cyc);
        end else begin
          exp_t e;
          e = qpop(i);
          check($sformatf("dut%0d_data", i),    data[i],            e.data);
          check($sformatf("dut%0d_timeout", i), timeout[i],         e.to);
          check($sformatf("dut%0d_latency", i), cyc - acc_cyc[i],   e.lat);
          check($sformatf("dut%0d_pulses", i),  pulses[i],          e.pulses);
          check($sformatf("dut%0d_rsrw_stable", i), bad_rsrw[i],   1'b0);
          check($sformatf("dut%0d_done_pins", i), {lcd_rw[i], lcd_rs[i], lcd_e[i]}, 3'b000);
        end
      end
      db[i]     = tab[i][(falls[i] < 7) ? falls[i] : 7];
      busy_p[i] = busy[i];
      e_p[i]    = lcd_e[i];
    end
  end

  // Load the bus table, set the request inputs and pulse start for one cycle.
  task automatic issue(input int i, input logic rs, input logic pl,
                       input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3,
                       input bit push_it, input exp_t e);
    @(negedge clk);
    tab[i][0] = b0; tab[i][1] = b1; tab[i][2] = b2;
    for (int k = 3; k < 8; k++) tab[i][k] = b3;
    rs_in[i] = rs;
    poll[i]  = pl;
    if (push_it) qpush(i, e);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    for (int k = 0; k < 2000 && (qsz(i) != 0 || busy[i] !== 1'b0); k++) @(negedge clk);
    check($sformatf("dut%0d_drained", i), qsz(i) + ((busy[i] === 1'b0) ? 0 : 1), 0);
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0; rs_in[i] = 1'b0; poll[i] = 1'b0;
      busy_p[i] = 1'b0; e_p[i] = 1'b0; cur_rs[i] = 1'b0; bad_rsrw[i] = 1'b0;
      acc_cyc[i] = 0; fall_cyc[i] = 0; pulses[i] = 0; falls[i] = 0;
      for (int k = 0; k < 8; k++) tab[i][k] = 8'h00;
      db[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset values: busy, done, timeout, lcd_rs, lcd_rw, lcd_e, data.
    for (int i = 0; i < 3; i++)
      check($sformatf("dut%0d_reset_values", i),
            {busy[i], done[i], timeout[i], lcd_rs[i], lcd_rw[i], lcd_e[i], data[i]}, 14'h0);

    // Reset while E is high aborts the request with no done.
    expect_abort = 1'b1;
    issue(0, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, mk(8'h00, 1'b0, 0, 0, 1'b0, -1));
    for (int k = 0; k < 50 && lcd_e[0] !== 1'b1; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("abort_e_high_before_reset", lcd_e[0], 1'b1);
    #2 rst = 1'b0;
    #1;
    check("abort_lcd_e",  lcd_e[0],  1'b0);
    check("abort_lcd_rw", lcd_rw[0], 1'b0);
    check("abort_busy",   busy[0],   1'b0);
    check("abort_done",   done[0],   1'b0);
    check("abort_data",   data[0],   8'h00);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    expect_abort = 1'b0;

    // 8-bit data-RAM read.
    issue(0, 1'b1, 1'b0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 1'b1, mk(8'hA5, 1'b0, 14, 1, 1'b1, -1));
    drain(0);

    // 4-bit read: 3 then C on [7:4]; low bus bits are junk and must be ignored.
    issue(1, 1'b1, 1'b0, 8'h3F, 8'hCF, 8'h00, 8'h00, 1'b1, mk(8'h3C, 1'b0, 26, 2, 1'b1, -1));
    drain(1);

    // Polled BF read: busy for 3 reads, then clear.
    issue(0, 1'b0, 1'b1, 8'h85, 8'h85, 8'h85, 8'h05, 1'b1, mk(8'h05, 1'b0, 50, 4, 1'b0, -1));
    drain(0);

    // BF read without poll: single read, no timeout even with BF set.
    issue(0, 1'b0, 1'b0, 8'h80, 8'h80, 8'h80, 8'h80, 1'b1, mk(8'h80, 1'b0, 14, 1, 1'b0, -1));
    drain(0);

    // MAX_POLLS=3 with BF stuck: three reads then timeout.
    issue(2, 1'b0, 1'b1, 8'h80, 8'h80, 8'h80, 8'h80, 1'b1, mk(8'h80, 1'b1, 38, 3, 1'b0, -1));
    drain(2);

    // MAX_POLLS=3, BF already clear on the first read.
    issue(2, 1'b0, 1'b1, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b1, mk(8'h7F, 1'b0, 14, 1, 1'b0, -1));
    drain(2);

    // 4-bit polled read: 8/0 (BF set), then 2/5.
    issue(1, 1'b0, 1'b1, 8'h8F, 8'h0F, 8'h2F, 8'h5F, 1'b1, mk(8'h25, 1'b0, 50, 4, 1'b0, -1));
    drain(1);

    // start held high, poll=1 with rs=1: single reads back to back, one idle
    // cycle between them.
    @(negedge clk);
    for (int k = 0; k < 8; k++) tab[0][k] = 8'hC3;
    qpush(0, mk(8'hC3, 1'b0, 14, 1, 1'b1, -1));
    qpush(0, mk(8'hC3, 1'b0, 14, 1, 1'b1, 1));
    qpush(0, mk(8'hC3, 1'b0, 14, 1, 1'b1, 1));
    rs_in[0] = 1'b1;
    poll[0]  = 1'b1;
    start[0] = 1'b1;
    begin
      int   accepts;
      logic prev;
      accepts = 0;
      prev    = busy[0];
      for (int k = 0; k < 200 && accepts < 3; k++) begin
        @(negedge clk);
        if (busy[0] === 1'b1 && prev !== 1'b1) accepts++;
        prev = busy[0];
      end
      start[0] = 1'b0;
      check("held_start_accepts", accepts, 3);
    end
    drain(0);
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
